// File: rtl/riscv_defines.sv
// Shared core definitions: word width and memory-arbiter owner encoding.
package riscv_defines;

    localparam int WORD_WIDTH = 32;

    typedef enum logic {
        ARB_OWNER_DATA  = 1'b0,
        ARB_OWNER_INSTR = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order owner-ID FIFO for the memory arbiter (depth 1..4, one owner per entry).
module arb_id_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  arb_owner_e din,
    output logic       full,
    output logic       empty,
    output arb_owner_e head
);

    // Storage sized for the largest legal depth; only DEPTH slots are used.
    arb_owner_e    mem_q [4];
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [2:0]    count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 3'(DEPTH));
    assign empty   = (count == 3'd0);
    assign head    = mem_q[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr] <= din;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter onto one req/gnt/rvalid memory port.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed data priority.
module mem_arbiter
    import riscv_defines::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    input  logic [WORD_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [WORD_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [WORD_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [WORD_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [WORD_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [WORD_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] mem_rdata_i,
    output logic                  err_o
);

    arb_owner_e owner;
    arb_owner_e lock_owner_q;
    arb_owner_e fifo_head;
    arb_owner_e prio;
    logic       locked_q;
    logic       owner_req;
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_e rr_prio_q;

    // Priority goes to whichever port was not accepted last; moves on acceptance only.
    always_ff @(posedge clk) begin
        if (rst)         rr_prio_q <= ARB_OWNER_DATA;
        else if (accept) rr_prio_q <= (owner == ARB_OWNER_DATA) ? ARB_OWNER_INSTR : ARB_OWNER_DATA;
    end

    assign prio = rr_prio_q;
`else
    assign prio = ARB_OWNER_DATA;
`endif

    // Owner select: a stalled request keeps the port until it is accepted.
    always_comb begin
        owner = ARB_OWNER_DATA;
        if (locked_q)                       owner = lock_owner_q;
        else if (data_req_i && instr_req_i) owner = prio;
        else if (instr_req_i)               owner = ARB_OWNER_INSTR;
    end

    // Memory port mux; instruction fetches are always full-word reads.
    always_comb begin
        owner_req   = data_req_i;
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
        if (owner == ARB_OWNER_INSTR) begin
            owner_req   = instr_req_i;
            mem_addr_o  = instr_addr_i;
            mem_we_o    = 1'b0;
            mem_be_o    = 4'hF;
            mem_wdata_o = '0;
        end
    end

    assign mem_req_o      = !rst && !fifo_full && owner_req;
    assign accept         = mem_req_o && mem_gnt_i;
    assign data_gnt_o     = accept && (owner == ARB_OWNER_DATA);
    assign instr_gnt_o    = accept && (owner == ARB_OWNER_INSTR);

    assign fifo_pop       = !rst && mem_rvalid_i && !fifo_empty;
    assign data_rvalid_o  = fifo_pop && (fifo_head == ARB_OWNER_DATA);
    assign instr_rvalid_o = fifo_pop && (fifo_head == ARB_OWNER_INSTR);
    assign data_rdata_o   = mem_rdata_i;
    assign instr_rdata_o  = mem_rdata_i;

    // Lock tracking and sticky orphan-response error.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q     <= 1'b0;
            lock_owner_q <= ARB_OWNER_DATA;
            err_o        <= 1'b0;
        end else begin
            locked_q     <= mem_req_o && !mem_gnt_i;
            lock_owner_q <= owner;
            if (mem_rvalid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (fifo_pop),
        .din   (owner),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_OUTSTANDING = 2).
module tb_mem_arbiter;
    import riscv_defines::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [WORD_WIDTH-1:0] instr_addr_i, instr_rdata_o;
    logic                  data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [3:0]            data_be_i;
    logic [WORD_WIDTH-1:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic                  mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
    logic [3:0]            mem_be_o;
    logic [WORD_WIDTH-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    task automatic idle();
        instr_req_i  = 1'b0; instr_addr_i = '0;
        data_req_i   = 1'b0; data_addr_i  = '0; data_we_i = 1'b0;
        data_be_i    = 4'h0; data_wdata_i = '0;
        mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 00000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        idle();
        sample();
        n_tests++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", err_o); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single_instr();
        instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
        sample();
        n_tests++;
        if ({instr_gnt_o, data_gnt_o, mem_req_o} !== 3'b101) begin
            n_fail++; $display("FAIL single_gnt: got %b exp 101", {instr_gnt_o, data_gnt_o, mem_req_o});
        end
        n_tests++;
        if ({mem_addr_o, mem_we_o, mem_be_o} !== {32'h100, 1'b0, 4'hF}) begin
            n_fail++; $display("FAIL single_addr: got %h/%b/%h exp 100/0/f", mem_addr_o, mem_we_o, mem_be_o);
        end
        next_cycle();
        idle();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL single_rvalid: got %b rdata %h exp 10 deadbeef",
                               {instr_rvalid_o, data_rvalid_o}, instr_rdata_o);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_lock();
        instr_req_i = 1'b1; instr_addr_i = 32'h104;
        data_req_i  = 1'b1; data_addr_i  = 32'h200; data_we_i = 1'b1;
        data_be_i   = 4'h3; data_wdata_i = 32'h55;
        for (int c = 0; c < 4; c++) begin
            mem_gnt_i = (c == 3);
            sample();
            n_tests++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_we_o !== 1'b1 || mem_be_o !== 4'h3) begin
                n_fail++; $display("FAIL lock_owner_c%0d: got req %b addr %h we %b be %h exp 1 200 1 3",
                                   c, mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
            end
            n_tests++;
            if ({data_gnt_o, instr_gnt_o} !== {(c == 3), 1'b0}) begin
                n_fail++; $display("FAIL lock_gnt_c%0d: got %b exp %b", c, {data_gnt_o, instr_gnt_o}, {(c == 3), 1'b0});
            end
            next_cycle();
        end
        // Data accepted; instruction takes the port and stalls.
        data_req_i = 1'b0; mem_gnt_i = 1'b0;
        sample();
        n_tests++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h104 || mem_we_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL lock_instr_sel: got req %b addr %h we %b gnt %b exp 1 104 0 0",
                               mem_req_o, mem_addr_o, mem_we_o, instr_gnt_o);
        end
        next_cycle();
        // Data returns but the locked instruction request keeps the port.
        data_req_i = 1'b1; mem_gnt_i = 1'b1;
        sample();
        n_tests++;
        if (mem_addr_o !== 32'h104 || {instr_gnt_o, data_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL lock_hold: got addr %h gnt %b exp 104 10", mem_addr_o, {instr_gnt_o, data_gnt_o});
        end
        next_cycle();
        idle();
        mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_fail++; $display("FAIL lock_resp0: got %b exp 01", {instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_fail++; $display("FAIL lock_resp1: got %b exp 10", {instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_outstanding();
        instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
        next_cycle();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h304;
        sample();
        n_tests++;
        if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL outst_second: got %b exp 1", data_gnt_o); end
        next_cycle();
        // FIFO full: blocked even though a pop happens this cycle.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11;
        sample();
        n_tests++;
        if ({mem_req_o, data_gnt_o, instr_gnt_o} !== 3'b000) begin
            n_fail++; $display("FAIL outst_block: got %b exp 000", {mem_req_o, data_gnt_o, instr_gnt_o});
        end
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_fail++; $display("FAIL outst_resp0: got %b exp 10", {instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
        sample();
        n_tests++;
        if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL outst_unblock: got %b exp 1", mem_req_o); end
        next_cycle();
        data_req_i = 1'b0; mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_fail++; $display("FAIL outst_resp1: got %b exp 01", {instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
        next_cycle();
        // Push and pop in the same cycle.
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h404; mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 3'b110) begin
            n_fail++; $display("FAIL b2b_pushpop: got %b exp 110", {data_gnt_o, instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        data_req_i = 1'b0; mem_gnt_i = 1'b0;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_order: got %b exp 01", {instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        idle();
        sample();
        n_tests++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL b2b_no_err: got %b exp 0", err_o); end
        next_cycle();
    endtask

    task automatic test_err();
        mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b000) begin
            n_fail++; $display("FAIL err_orphan: got %b exp 000", {instr_rvalid_o, data_rvalid_o, err_o});
        end
        next_cycle();
        idle();
        sample();
        n_tests++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b exp 1", err_o); end
        next_cycle();
        next_cycle();
        sample();
        n_tests++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b exp 1", err_o); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        sample();
        n_tests++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b exp 0", err_o); end
        next_cycle();
    endtask

    task automatic test_arb_policy();
        logic exp_d [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid_i = (i > 0);
            sample();
            n_tests++;
            if ({data_gnt_o, instr_gnt_o} !== {exp_d[i], !exp_d[i]}) begin
                n_fail++; $display("FAIL policy_gnt_%0d: got %b exp %b", i, {data_gnt_o, instr_gnt_o}, {exp_d[i], !exp_d[i]});
            end
            if (i > 0) begin
                n_tests++;
                if ({data_rvalid_o, instr_rvalid_o} !== {exp_d[i-1], !exp_d[i-1]}) begin
                    n_fail++; $display("FAIL policy_resp_%0d: got %b exp %b", i,
                                       {data_rvalid_o, instr_rvalid_o}, {exp_d[i-1], !exp_d[i-1]});
                end
            end
            next_cycle();
        end
        idle();
        mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({data_rvalid_o, instr_rvalid_o} !== {exp_d[3], !exp_d[3]}) begin
            n_fail++; $display("FAIL policy_drain: got %b exp %b", {data_rvalid_o, instr_rvalid_o}, {exp_d[3], !exp_d[3]});
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        instr_req_i = 1'b1; instr_addr_i = 32'h500; mem_gnt_i = 1'b1;
        next_cycle();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h504;
        next_cycle();
        // Two outstanding; reset with every input active.
        rst = 1'b1; instr_req_i = 1'b1; mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== 5'b0) begin
            n_fail++; $display("FAIL rmid_outputs: got %b exp 00000",
                               {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o});
        end
        next_cycle();
        rst = 1'b0; idle();
        data_req_i = 1'b1; mem_rvalid_i = 1'b1;
        sample();
        n_tests++;
        if ({instr_rvalid_o, data_rvalid_o, mem_req_o} !== 3'b001) begin
            n_fail++; $display("FAIL rmid_stale: got %b exp 001", {instr_rvalid_o, data_rvalid_o, mem_req_o});
        end
        next_cycle();
        idle();
        sample();
        n_tests++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL rmid_err: got %b exp 1", err_o); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next_cycle();
        test_reset();
        test_single_instr();
        test_lock();
        test_outstanding();
        test_back_to_back();
        test_err();
        test_arb_policy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
